// File: rtl/apb_pkg.sv
// Shared types for the APB master controller: FSM state encoding and
// response error codes.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command/response side plus APB bus of the master controller in one bundle;
// "master" is the controller view, "slave" is the view of whoever drives it.
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  PREADY, PSLVERR, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output PREADY, PSLVERR, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-cycle counter; expired flags the cycle that is the
// TIMEOUT-th ACCESS cycle of the current transfer.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int             CW    = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

            // count holds completed ACCESS cycles, so the current cycle is count+1
            logic [CW-1:0] count;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != LIMIT)) begin
                    count <= count + CW'(1);
                end
            end

            assign expired = enable && (count >= (LIMIT - CW'(1)));
        end
    endgenerate

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: accepts a command in IDLE, runs SETUP/ACCESS,
// and returns a one-cycle response with optional ACCESS timeout.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic             PCLK,
    input logic             PRESETn,
    apb_master_ctrl_if.master bus
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e state_q;
    apb_state_e state_d;
    logic       accept;
    logic       expired;

    assign accept        = (state_q == ST_IDLE) && bus.cmd_valid;
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.PSEL      = (state_q != ST_IDLE);
    assign bus.PENABLE   = (state_q == ST_ACCESS);

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (accept),
        .enable  (state_q == ST_ACCESS),
        .expired (expired)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (bus.PREADY || expired) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= RSP_OK;
        end else begin
            state_q       <= state_d;
            bus.rsp_valid <= 1'b0;

            if (accept) begin
                bus.PADDR  <= bus.cmd_addr;
                bus.PWRITE <= bus.cmd_write;
                if (bus.cmd_write) begin
                    bus.PWDATA <= bus.cmd_wdata;
                    bus.PSTRB  <= bus.cmd_strb;
                end else begin
                    bus.PSTRB  <= '0;
                end
            end

            // PREADY wins over an expiring count on the same edge
            if (state_q == ST_ACCESS) begin
                if (bus.PREADY) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
                    bus.rsp_err   <= bus.PSLVERR ? RSP_SLVERR : RSP_OK;
                end else if (expired) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= RSP_TIMEOUT;
                end
            end
        end
    end

    logic unused_strb_w;
    assign unused_strb_w = (STRB_W == 0);

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, PADDR and cmd_addr width.
REQ-002 Parameter DATA_W, default 32, data width; legal values 8, 16, 32, 64.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.
REQ-004 PCLK  input  1  single clock; all logic on rising edge.
REQ-005 PRESETn  input  1  synchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 cmd_strb  input  DATA_W/8  write byte strobes.
REQ-012 rsp_valid  output  1  single-cycle completion pulse.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and aborted transfers.
REQ-014 rsp_err  output  2  00 OK, 01 SLVERR, 10 TIMEOUT.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-016 PADDR  output  ADDR_W; PWDATA  output  DATA_W; PSTRB  output  DATA_W/8.
REQ-017 PREADY, PSLVERR  input  1 each; PRDATA  input  DATA_W.

Function
REQ-018 FSM states: IDLE, SETUP and ACCESS; no other states.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1; the cmd_* inputs are ignored at all other times.
REQ-020 On accept: register cmd_addr, cmd_write, cmd_wdata and cmd_strb onto the P* outputs; next state SETUP.
REQ-021 SETUP: PSEL=1, PENABLE=0 for exactly one cycle; next state ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA and PSTRB held stable from SETUP until exit.
REQ-023 ACCESS exit on an edge with PREADY=1: capture PRDATA (reads only) and PSLVERR into rsp_err (01 if set); next state IDLE.
REQ-024 rsp_valid SHALL pulse for exactly one cycle, the first IDLE cycle after ACCESS exit; rsp_rdata and rsp_err hold until the next rsp_valid.
REQ-025 Latency: with a command accepted at edge N and zero wait states, SETUP occupies cycle N+1, ACCESS occupies N+2, and rsp_valid=1 in N+3; back-to-back commands sustain one transfer per 3 cycles.
REQ-026 A command presented during the rsp_valid cycle SHALL be accepted at that cycle's edge.
REQ-027 Reads SHALL drive PSTRB=0; PWDATA keeps its last value for reads and in IDLE.
REQ-028 Timeout (TIMEOUT>0): count ACCESS cycles from 1; on the edge where the count equals TIMEOUT and PREADY=0, exit to IDLE with rsp_err=10 and rsp_rdata=0.
REQ-029 PREADY=1 on the same edge the count reaches TIMEOUT SHALL complete normally; PREADY takes precedence over the timeout.
REQ-030 The counter SHALL saturate and never wrap; it clears on entry to SETUP.
REQ-031 In IDLE, PSEL=0 and PENABLE=0; PADDR, PWRITE and PSTRB hold their last values.

Reset
REQ-032 When PRESETn=0 at a rising edge: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, timeout count=0.
REQ-033 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort with no rsp_valid; cmd_ready=1 in the first cycle after PRESETn returns to 1.

Structure
REQ-034 Package apb_pkg SHALL hold the FSM state enum and the rsp_err codes RSP_OK, RSP_SLVERR and RSP_TIMEOUT.
REQ-035 One sub-module, apb_timeout_cnt (parameter TIMEOUT; inputs clear and enable; output expired), SHALL implement the saturating counter.

Verification
REQ-036 Write 0x0000_0010 with data 0xDEAD_BEEF, strb 0xF, PREADY tied to 1 -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 with rsp_err=00, and PSTRB=0xF observed during ACCESS.
REQ-037 Read 0x0000_0020, PREADY low for 3 cycles, PRDATA=0x1234_5678 -> 4 ACCESS cycles, rsp_rdata=0x1234_5678, PSTRB=0 throughout.
REQ-038 Read with PSLVERR=1 on the PREADY cycle -> rsp_err=01.
REQ-039 TIMEOUT=4, PREADY held at 0 -> exit after 4 ACCESS cycles with rsp_err=10 and rsp_rdata=0; repeat with PREADY=1 on the 4th ACCESS cycle -> rsp_err=00.
REQ-040 Two back-to-back commands, cmd_valid held high -> second SETUP immediately follows the first rsp_valid cycle; PSEL low for exactly one cycle between transfers.
REQ-041 PRESETn=0 during ACCESS -> PSEL=0 and PENABLE=0 next cycle, no rsp_valid, and cmd_ready=1 after release.
